// File: rtl/uart_tx_fifo_mmio.sv
// uart_tx_fifo_mmio
//   Memory-mapped buffered UART transmitter. CPU stores to TXDATA are queued
//   in a byte FIFO and sent 8N1 on uart_tx, so the CPU never stalls. STATUS
//   reports the FIFO level, overflow, empty, full and busy. Writing STATUS can
//   flush the FIFO (bit 0) and clear the overflow flag (bit 3). Read data is
//   registered, so it is valid the cycle after the address is presented.
// Ports
//   clk           system clock, all state on posedge
//   reset         asynchronous, active-high reset
//   memAddress    CPU byte address
//   memWriteData  CPU store data
//   memWrite      store strobe, one cycle per access
//   byteMask      byte-lane enables for stores (lane 0 qualifies all writes)
//   memReadData   registered read data, 0 when the block is not selected
//   uart_tx       serial output, idle high
module uart_tx_fifo_mmio #(
  parameter logic [31:0] BASE_MEMORY  = 32'hFFFF_FFE8,
  parameter logic [31:0] TOP_MEMORY   = 32'hFFFF_FFEF,
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  input  logic [31:0] memWriteData,
  input  logic        memWrite,
  input  logic [3:0]  byteMask,
  output logic [31:0] memReadData,
  output logic        uart_tx
);

  localparam int PW = $clog2(FIFO_DEPTH) + 1;  // pointer width incl. wrap bit
  localparam int AW = PW - 1;                  // storage index width
  localparam int CW = $clog2(CLKS_PER_BIT);    // bit timer width

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] LEVEL_FULL = PW'(FIFO_DEPTH);

  logic [31:0]   off;
  logic          sel;
  logic          wr_en;
  logic          push_req;
  logic          status_wr;
  logic [PW-1:0] level;
  logic          full;
  logic          empty;
  logic          pop;
  logic [31:0]   status_word;
  logic          unused_bits;

  logic [7:0]    fifo_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PW-1:0] rd_ptr_d, rd_ptr_q;
  logic          ovf_d, ovf_q;
  logic [1:0]    state_d, state_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [2:0]    idx_d, idx_q;
  logic [7:0]    shreg_d, shreg_q;
  logic          tx_d, tx_q;
  logic [31:0]   rdata_d, rdata_q;

  assign sel       = (memAddress >= BASE_MEMORY) && (memAddress <= TOP_MEMORY);
  assign off       = memAddress - BASE_MEMORY;
  assign wr_en     = sel && memWrite && byteMask[0];
  assign push_req  = wr_en && !off[2];
  assign status_wr = wr_en && off[2];

  // Level is the pointer difference; the extra wrap bit tells full from empty.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == LEVEL_FULL);
  assign empty = (level == PW'(0));

  // Address bits and data lanes this block never looks at.
  assign unused_bits = ^{off[31:3], off[1:0], memWriteData[31:8], byteMask[3:1]};

  assign memReadData = rdata_q;
  assign uart_tx     = tx_q;

  // FIFO storage: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (push_req && !full) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= memWriteData[7:0];
    end
  end

  // Next-state logic: transmit FSM, FIFO pointers, overflow and read mux.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pop = !empty;
      end
      ST_START: begin
        if (cnt_q == CW'(0)) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CW'(0)) begin
          cnt_d = CNT_RELOAD;
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CW'(0)) begin
          // Back-to-back frames: a waiting byte starts right after the stop bit.
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (pop) begin
      shreg_d  = fifo_mem[rd_ptr_q[AW-1:0]];
      cnt_d    = CNT_RELOAD;
      state_d  = ST_START;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      shreg_d = shreg_d;
    end

    // Full is judged on the start-of-cycle level, so a same-cycle pop does not
    // make room for the byte.
    if (push_req) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Flush overrides a same-cycle pop; the byte already loaded still goes out.
    if (status_wr) begin
      if (memWriteData[0]) begin
        rd_ptr_d = wr_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_d;
      end
      if (memWriteData[3]) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_d;
      end
    end else begin
      ovf_d = ovf_d;
    end

    // Line level follows the next state so uart_tx comes straight from a flop.
    case (state_d)
      ST_IDLE:  tx_d = 1'b1;
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_d[idx_d];
      ST_STOP:  tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    status_word            = 32'h0000_0000;
    status_word[8 +: PW]   = level;
    status_word[3]         = ovf_q;
    status_word[2]         = empty;
    status_word[1]         = full;
    status_word[0]         = (state_q != ST_IDLE);

    if (sel && off[2]) begin
      rdata_d = status_word;
    end else begin
      rdata_d = 32'h0000_0000;
    end
  end

  // State registers; reset drops any frame in flight and forces the line idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shreg_q  <= 8'h00;
      tx_q     <= 1'b1;
      rdata_q  <= 32'h0000_0000;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shreg_q  <= shreg_d;
      tx_q     <= tx_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_mmio.sv
// Testbench for uart_tx_fifo_mmio (CLKS_PER_BIT=4, FIFO_DEPTH=16).
// The reference model keeps a list of scheduled frames (byte + pop time);
// the line level, busy, level and overflow are derived from that list.
module tb_uart_tx_fifo_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE = 32'hFFFF_FFE8;
  localparam logic [31:0] TOP  = 32'hFFFF_FFEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;
  logic        uart_tx;

  uart_tx_fifo_mmio #(
    .BASE_MEMORY (BASE),
    .TOP_MEMORY  (TOP),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .memAddress  (memAddress),
    .memWriteData(memWriteData),
    .memWrite    (memWrite),
    .byteMask    (byteMask),
    .memReadData (memReadData),
    .uart_tx     (uart_tx)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int         q;   // clock edge at which the byte leaves the FIFO
    logic [7:0] b;
  } frame_t;

  frame_t frames[$];
  int     last_pop;
  logic   m_ovf;
  int     now = 0;   // index of the last clock edge processed

  // receiver decoding the DUT line
  logic       rx_active;
  int         rx_t0;
  logic [7:0] rx_byte;
  logic [7:0] rx_q[$];

  function automatic int m_level(input int t);
    int n = 0;
    foreach (frames[i]) if (frames[i].q > t) n++;
    return n;
  endfunction

  function automatic logic m_busy(input int t);
    logic b = 1'b0;
    foreach (frames[i]) if (frames[i].q <= t && t < frames[i].q + FRAME) b = 1'b1;
    return b;
  endfunction

  function automatic logic m_tx(input int t);
    logic v = 1'b1;
    int   k;
    foreach (frames[i]) begin
      if (frames[i].q <= t && t < frames[i].q + FRAME) begin
        k = (t - frames[i].q) / CPB;
        if (k == 0) v = 1'b0;
        else if (k <= 8) v = frames[i].b[k-1];
        else v = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] m_status(input int t);
    logic [31:0] s;
    int lvl;
    lvl = m_level(t);
    s = 32'h0000_0000;
    s[12:8] = lvl[4:0];
    s[3] = m_ovf;
    s[2] = (lvl == 0);
    s[1] = (lvl == DEPTH);
    s[0] = m_busy(t);
    return s;
  endfunction

  task automatic m_reset();
    frames.delete();
    last_pop  = -1000;
    m_ovf     = 1'b0;
    rx_active = 1'b0;
  endtask

  task automatic set_read(input logic [31:0] addr);
    memAddress   = addr;
    memWrite     = 1'b0;
    memWriteData = $urandom;
    byteMask     = 4'($urandom);
  endtask

  task automatic set_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    memAddress   = addr;
    memWrite     = 1'b1;
    memWriteData = data;
    byteMask     = mask;
  endtask

  // One clock: model the edge, then check read data and line at the negedge.
  task automatic step();
    logic [31:0] exp_rd;
    logic [31:0] off;
    logic        sel;
    logic        v;
    int          d;
    frame_t      f;
    frame_t      keep[$];
    sel = (memAddress >= BASE) && (memAddress <= TOP);
    off = memAddress - BASE;
    if (reset) exp_rd = 32'h0;
    else exp_rd = (sel && off[2]) ? m_status(now) : 32'h0;
    @(posedge clk);
    now++;
    if (reset) begin
      m_reset();
    end else if (sel && memWrite && byteMask[0]) begin
      if (!off[2]) begin
        if (m_level(now - 1) == DEPTH) begin
          m_ovf = 1'b1;
        end else begin
          f.q = (now + 1 > last_pop + FRAME) ? now + 1 : last_pop + FRAME;
          f.b = memWriteData[7:0];
          frames.push_back(f);
          last_pop = f.q;
        end
      end else begin
        if (memWriteData[0]) begin
          foreach (frames[i]) if (frames[i].q <= now) keep.push_back(frames[i]);
          frames   = keep;
          last_pop = -1000;
          foreach (frames[i]) if (frames[i].q > last_pop) last_pop = frames[i].q;
        end
        if (memWriteData[3]) m_ovf = 1'b0;
      end
    end
    @(negedge clk);
    check_value("rdata", memReadData, exp_rd);
    check_value("uart_tx", {31'd0, uart_tx}, {31'd0, (reset ? 1'b1 : m_tx(now))});
    v = uart_tx;
    if (!rx_active) begin
      if (v == 1'b0 && !reset) begin
        rx_active = 1'b1;
        rx_t0     = now;
      end
    end else begin
      d = now - rx_t0;
      if (d % CPB == CPB / 2 && d / CPB >= 1 && d / CPB <= 8) rx_byte[d/CPB-1] = v;
      if (d == 9 * CPB + CPB / 2) begin
        rx_q.push_back(rx_byte);
        rx_active = 1'b0;
      end
    end
  endtask

  task automatic idle_steps(input int n, input logic [31:0] addr);
    for (int i = 0; i < n; i++) begin
      set_read(addr);
      step();
    end
  endtask

  logic [7:0] bytes[18];
  int         busy_cnt;
  int         r;
  logic [31:0] a;

  initial begin
    m_reset();
    reset = 1'b1;
    set_read(BASE + 32'd4);
    step();
    step();
    reset = 1'b0;

    // 1: reset state
    check_value("t1_tx_idle", {31'd0, uart_tx}, 32'd1);
    set_read(BASE + 32'd4);
    step();
    check_value("t1_status", memReadData, 32'h0000_0004);
    set_read(32'h0000_0100);
    step();
    check_value("t1_unmapped", memReadData, 32'h0000_0000);

    // 2: single frame 0x55
    rx_q.delete();
    set_write(BASE, 32'h0000_0055, 4'b0001);
    step();
    busy_cnt = 0;
    for (int i = 0; i < 45; i++) begin
      set_read(BASE + 32'd4);
      step();
      busy_cnt += int'(memReadData[0]);
    end
    check_value("t2_busy_clks", busy_cnt, 32'd40);
    check_value("t2_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check_value("t2_rx_byte", {24'd0, rx_q[0]}, 32'h55);

    // 3: back-to-back frames
    rx_q.delete();
    set_write(BASE, 32'h0000_00A5, 4'b0001);
    step();
    set_write(BASE, 32'h0000_003C, 4'b0001);
    step();
    busy_cnt = 0;
    for (int i = 0; i < 85; i++) begin
      set_read(BASE + 32'd4);
      step();
      busy_cnt += int'(memReadData[0]);
    end
    check_value("t3_busy_clks", busy_cnt, 32'd80);
    check_value("t3_rx_count", rx_q.size(), 32'd2);
    if (rx_q.size() > 1) begin
      check_value("t3_rx_b0", {24'd0, rx_q[0]}, 32'hA5);
      check_value("t3_rx_b1", {24'd0, rx_q[1]}, 32'h3C);
    end

    // 4: overflow with 18 consecutive writes
    rx_q.delete();
    for (int i = 0; i < 18; i++) begin
      bytes[i] = 8'($urandom);
      set_write(BASE, {24'd0, bytes[i]}, 4'b0001);
      step();
    end
    set_read(BASE + 32'd4);
    step();
    check_value("t4_full_status", memReadData, 32'h0000_100B);
    idle_steps(17 * FRAME + 10, BASE + 32'd4);
    check_value("t4_rx_count", rx_q.size(), 32'd17);
    for (int i = 0; i < 17; i++) begin
      if (i < rx_q.size()) check_value("t4_rx_byte", {24'd0, rx_q[i]}, {24'd0, bytes[i]});
    end
    check_value("t4_ovf_sticky", memReadData, 32'h0000_000C);
    set_write(BASE + 32'd4, 32'h0000_0008, 4'b0001);
    step();
    set_read(BASE + 32'd4);
    step();
    check_value("t4_ovf_cleared", memReadData, 32'h0000_0004);

    // 5: flush during first frame
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      bytes[i] = 8'($urandom);
      set_write(BASE, {24'd0, bytes[i]}, 4'b0001);
      step();
    end
    idle_steps(10, BASE + 32'd4);
    set_write(BASE + 32'd4, 32'h0000_0001, 4'b0001);
    step();
    set_read(BASE + 32'd4);
    step();
    check_value("t5_flushed", memReadData, 32'h0000_0005);
    idle_steps(90, BASE + 32'd4);
    check_value("t5_rx_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check_value("t5_rx_byte", {24'd0, rx_q[0]}, {24'd0, bytes[0]});
    check_value("t5_idle", memReadData, 32'h0000_0004);

    // 6: reset mid-DATA
    rx_q.delete();
    set_write(BASE, 32'h0000_0000, 4'b0001);
    step();
    idle_steps(10, BASE + 32'd4);
    check_value("t6_in_frame", {31'd0, uart_tx}, 32'd0);
    reset = 1'b1;
    #1;
    check_value("t6_tx_async", {31'd0, uart_tx}, 32'd1);
    check_value("t6_rd_async", memReadData, 32'h0);
    step();
    step();
    reset = 1'b0;
    set_read(BASE + 32'd4);
    step();
    check_value("t6_status", memReadData, 32'h0000_0004);
    idle_steps(60, BASE + 32'd4);
    check_value("t6_no_resume", rx_q.size(), 32'd0);

    // 7: randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 22) begin
        set_write(BASE + 32'($urandom_range(0, 3)), $urandom, 4'($urandom));
      end else if (r < 25) begin
        set_write(BASE + 32'd4 + 32'($urandom_range(0, 3)), $urandom, 4'($urandom));
      end else if (r < 33) begin
        a = ($urandom_range(0, 1) == 0) ? BASE - 32'd1 : TOP + 32'd1;
        if ($urandom_range(0, 3) == 0) a = $urandom & 32'h7FFF_FFFF;
        set_write(a, $urandom, 4'hF);
      end else begin
        a = BASE + 32'($urandom_range(0, 8));
        if ($urandom_range(0, 7) == 0) a = BASE - 32'd1;
        set_read(a);
      end
      step();
    end
    idle_steps(20 * FRAME, BASE + 32'd4);
    check_value("t7_drained", memReadData & 32'h0000_1F07, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
